risc_control_unit: RTL

Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Fetches instructions from a 32-word unified memory over a req/ack handshake.
- Reads operands and drives the registered 8-bit ALU: sel codes ADD, ASHL, XNOR, DIV2, LOAD, STORE, COMP2S, ROUND = 0..7.
- Writes results back to the accumulator or to memory.
- Owns PC, IR, MDR, ACC and the carry flag.

---
 rtl/risc_control_unit_if.sv | 20 ++
 rtl/risc_control_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/risc_control_unit_if.sv
// Memory bus between the sequencer and the unified 32-word memory.
// The master holds req/we/addr/wdata steady until the slave returns ack.
interface risc_control_unit_if;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/risc_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU; RISC_SINGLE_STEP_EN adds step/PAUSE.
// Latency: ALU op 5 clk, LOAD 4, STORE 3 with zero-wait memory; each memory wait adds 1 clk.
// Backpressure: requests are held stable until mem_ack; ack without a request is ignored.
module risc_control_unit #(
    parameter logic [4:0] START_ADDR = 5'd0,
    parameter logic [4:0] HALT_ADDR  = 5'd31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef RISC_SINGLE_STEP_EN
    input  logic       step,
`endif
    risc_control_unit_if.master mem,
    output logic [2:0] alu_sel,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    output logic [7:0] acc,
    output logic       carry,
    output logic [4:0] pc,
    output logic       busy,
    output logic       halted
);
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, READ, LDWB, EXEC, WB, WRITE, HALT
`ifdef RISC_SINGLE_STEP_EN
        , PAUSE
`endif
    } state_t;

`ifdef RISC_SINGLE_STEP_EN
    localparam state_t INSN_DONE = PAUSE;
`else
    localparam state_t INSN_DONE = FETCH;
`endif

    state_t     state, state_nxt;
    logic [7:0] ir, mdr;
    logic       req, we;
    logic [4:0] addr;
    logic       acked;

    assign alu_sel       = ir[7:5];
    assign alu_op1       = acc;
    assign alu_op2       = mdr;
    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = acc;
    assign acked         = req && mem.mem_ack;
    assign busy          = (state != IDLE) && (state != HALT);
    assign halted        = (state == HALT);

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        we        = 1'b0;
        addr      = pc;
        case (state)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH: begin
                // Halting is decided before any request, so addr HALT_ADDR is never fetched.
                if (pc == HALT_ADDR) begin
                    state_nxt = HALT;
                end else begin
                    req = 1'b1;
                    if (mem.mem_ack) state_nxt = DECODE;
                end
            end
            DECODE: state_nxt = (ir[7:5] == OP_STORE) ? WRITE : READ;
            READ: begin
                req  = 1'b1;
                addr = ir[4:0];
                if (mem.mem_ack) state_nxt = (ir[7:5] == OP_LOAD) ? LDWB : EXEC;
            end
            LDWB:   state_nxt = INSN_DONE;
            EXEC:   state_nxt = WB;
            WB:     state_nxt = INSN_DONE;
            WRITE: begin
                req  = 1'b1;
                we   = 1'b1;
                addr = ir[4:0];
                if (mem.mem_ack) state_nxt = INSN_DONE;
            end
            HALT:   if (start) state_nxt = FETCH;
`ifdef RISC_SINGLE_STEP_EN
            PAUSE:  if (step) state_nxt = FETCH;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= START_ADDR;
            ir    <= 8'd0;
            mdr   <= 8'd0;
            acc   <= 8'd0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, HALT: if (start) pc <= START_ADDR;
                FETCH:      if (acked) ir <= mem.mem_rdata;
                DECODE:     pc <= pc + 5'd1;
                READ:       if (acked) mdr <= mem.mem_rdata;
                LDWB:       acc <= mdr;
                WB: begin
                    acc   <= alu_out;
                    carry <= alu_co;
                end
                default: ;
            endcase
        end
    end
endmodule
